// File: rtl/db_pkg.sv
// Shared definitions for the key/value database path: operation flags,
// protocol constants recognised by the parser, and the parser FSM states.
package db_pkg;

  localparam logic [3:0]  OP_INSERT     = 4'h1;
  localparam logic [3:0]  OP_LOOKUP     = 4'h2;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL    = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;

  typedef enum logic [2:0] {
    ST_SYNC = 3'd0,
    ST_IDLE = 3'd1,
    ST_HDR  = 3'd2,
    ST_EOF  = 3'd3,
    ST_DROP = 3'd4
  } kx_state_e;

  // Big-endian 16-bit field starting at wire byte b of a 64-bit beat.
  function automatic logic [15:0] be16(input logic [63:0] d, input int unsigned b);
    return {d[8*b +: 8], d[8*(b+1) +: 8]};
  endfunction

endpackage

// File: rtl/pkt_key_extract_if.sv
// Receive-side AXI4-Stream tap. No tready: the sink consumes every valid beat.
interface pkt_key_extract_if;

  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser);
  modport slave  (input  tdata, tkeep, tvalid, tlast, tuser);

endinterface

// File: rtl/axis_beat_cnt.sv
// Beat-index counter for an AXI4-Stream tap. beat_idx is the index of the
// beat currently presented; it saturates at 5 because nothing past beat 4
// matters to the parser.
module axis_beat_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       tvalid,
  input  logic       tlast,
  output logic [2:0] beat_idx,
  output logic       sof,
  output logic       eof
);

  localparam logic [2:0] IDX_MAX = 3'd5;

  assign sof = tvalid && (beat_idx == 3'd0);
  assign eof = tvalid && tlast;

  // Advance on every valid beat, return to zero after the last beat of a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_idx <= 3'd0;
    end else if (tvalid) begin
      if (tlast)                  beat_idx <= 3'd0;
      else if (beat_idx != IDX_MAX) beat_idx <= beat_idx + 3'd1;
    end
  end

endmodule

// File: rtl/pkt_key_extract.sv
// Ethernet/IPv4/UDP header parser feeding the key/value database. Builds the
// 96-bit tuple key and an insert/lookup flag, and strobes them once per
// accepted, error-free frame in the cycle after its last beat.
module pkt_key_extract
  import db_pkg::*;
#(
  parameter int          KEY_SIZE   = 96,   // only 96 is supported
  parameter logic [15:0] ALERT_PORT = 16'd53
) (
  input  logic                clk,
  input  logic                rst,
  pkt_key_extract_if.slave    s_axis,
  output logic [KEY_SIZE-1:0] out_key,
  output logic [3:0]          out_flag,
  output logic                out_valid,
  output logic [31:0]         stat_keys
);

  // Beat indices and byte offsets of the header fields within a beat.
  localparam logic [2:0] BEAT_ETH   = 3'd1;
  localparam logic [2:0] BEAT_PROTO = 3'd2;
  localparam logic [2:0] BEAT_SRC   = 3'd3;
  localparam logic [2:0] BEAT_UDP   = 3'd4;
  localparam int unsigned OFS_ETYPE  = 4;
  localparam int unsigned OFS_VER    = 6;
  localparam int unsigned OFS_PROTO  = 7;
  localparam int unsigned OFS_SRC    = 2;
  localparam int unsigned OFS_DST_HI = 6;
  localparam int unsigned OFS_DST_LO = 0;
  localparam int unsigned OFS_SPORT  = 2;
  localparam int unsigned OFS_DPORT  = 4;

  kx_state_e             state_q, state_d;
  logic [2:0]            beat_idx;
  logic                  sof, eof;
  logic                  hdr_ok;
  logic                  emit;
  logic                  cap_src;
  logic                  cap_tail;
  logic [31:0]           src_q;
  logic [15:0]           dst_hi_q;
  logic [KEY_SIZE-1:0]   key_q;
  logic [3:0]            flag_q;
  logic [KEY_SIZE-1:0]   tail_key;
  logic [3:0]            tail_flag;
  logic [KEY_SIZE-1:0]   emit_key;
  logic [3:0]            emit_flag;
  logic [31:0]           stat_q;

  // Bytes 6..7 of the last header beat carry UDP length, not needed here.
  logic unused_keep;
  assign unused_keep = &{1'b0, s_axis.tkeep[7:6]};

  axis_beat_cnt u_beat_cnt (
    .clk      (clk),
    .rst      (rst),
    .tvalid   (s_axis.tvalid),
    .tlast    (s_axis.tlast),
    .beat_idx (beat_idx),
    .sof      (sof),
    .eof      (eof)
  );

  // Key and flag as they would be built from the current beat-4 data.
  always_comb begin
    tail_key  = {src_q, dst_hi_q,
                 be16(s_axis.tdata, OFS_DST_LO),
                 be16(s_axis.tdata, OFS_DPORT),
                 16'h0000};
    tail_flag = (be16(s_axis.tdata, OFS_SPORT) == ALERT_PORT) ? OP_INSERT : OP_LOOKUP;
  end

  // Per-beat header check for the beat currently presented in HDR.
  always_comb begin
    hdr_ok = 1'b0;
    unique case (beat_idx)
      BEAT_ETH:   hdr_ok = (be16(s_axis.tdata, OFS_ETYPE) == ETH_TYPE_IPV4) &&
                           (s_axis.tdata[8*OFS_VER +: 8] == IP_VER_IHL);
      BEAT_PROTO: hdr_ok = (s_axis.tdata[8*OFS_PROTO +: 8] == IP_PROTO_UDP);
      BEAT_SRC:   hdr_ok = 1'b1;
      BEAT_UDP:   hdr_ok = (s_axis.tkeep[5:0] == 6'h3F);
      default:    hdr_ok = 1'b0;
    endcase
  end

  // Next-state and strobe decision.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    emit     = 1'b0;
    cap_src  = 1'b0;
    cap_tail = 1'b0;
    unique case (state_q)
      ST_SYNC: if (eof) state_d = ST_IDLE;
      ST_IDLE: if (sof && !s_axis.tlast) state_d = ST_HDR;
      ST_HDR: begin
        if (s_axis.tvalid) begin
          cap_src = (beat_idx == BEAT_SRC);
          if (s_axis.tlast) begin
            state_d = ST_IDLE;
            emit    = hdr_ok && (beat_idx == BEAT_UDP) && !s_axis.tuser;
          end else if (!hdr_ok) begin
            state_d = ST_DROP;
          end else if (beat_idx == BEAT_UDP) begin
            state_d  = ST_EOF;
            cap_tail = 1'b1;
          end
        end
      end
      ST_EOF: begin
        if (eof) begin
          state_d = ST_IDLE;
          emit    = !s_axis.tuser;
        end
      end
      ST_DROP: if (eof) state_d = ST_IDLE;
      default: state_d = ST_SYNC;
    endcase
  end

  // A strobe from HDR uses the beat on the wire; from EOF the captured tail.
  assign emit_key  = (state_q == ST_HDR) ? tail_key  : key_q;
  assign emit_flag = (state_q == ST_HDR) ? tail_flag : flag_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) state_q <= ST_SYNC;
    else     state_q <= state_d;
  end

  // Header field capture; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    // NOTE: datapath holding registers skip reset; the FSM guarantees they are
    // written before they are read.
    if (cap_src) begin
      src_q    <= s_axis.tdata[8*OFS_SRC +: 32] == 32'h0 ? 32'h0 :
                  {s_axis.tdata[8*OFS_SRC +: 8],     s_axis.tdata[8*(OFS_SRC+1) +: 8],
                   s_axis.tdata[8*(OFS_SRC+2) +: 8], s_axis.tdata[8*(OFS_SRC+3) +: 8]};
      dst_hi_q <= be16(s_axis.tdata, OFS_DST_HI);
    end
    if (cap_tail) begin
      key_q  <= tail_key;
      flag_q <= tail_flag;
    end
  end

  // Output strobe, held key/flag and strobe counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_key   <= '0;
      out_flag  <= 4'h0;
      stat_q    <= 32'h0;
    end else begin
      out_valid <= emit;
      if (emit) begin
        out_key  <= emit_key;
        out_flag <= emit_flag;
        stat_q   <= stat_q + 32'd1;
      end
    end
  end

  assign stat_keys = stat_q;

endmodule

// File: tb/tb_pkt_key_extract.sv
// Directed bench for pkt_key_extract: builds frames byte by byte, drives them
// on the tap, records every strobe and compares against hand-computed keys.
module tb_pkt_key_extract;

  localparam logic [95:0] KEY_STD = 96'h0A000001_0A000002_115C_0000;
  localparam logic [95:0] KEY_C   = 96'h0A000003_0A000004_0050_0000;
  localparam logic [95:0] KEY_D   = 96'h0A000005_0A000006_1F90_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] out_key;
  logic [3:0]  out_flag;
  logic        out_valid;
  logic [31:0] stat_keys;

  pkt_key_extract_if axis_if ();

  pkt_key_extract #(.KEY_SIZE(96), .ALERT_PORT(16'd53)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_axis    (axis_if),
    .out_key   (out_key),
    .out_flag  (out_flag),
    .out_valid (out_valid),
    .stat_keys (stat_keys)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe recorder, sampled on the falling edge.
  logic [95:0] sk[$];
  logic [3:0]  sf[$];
  int          sc[$];
  always @(negedge clk) begin
    if (out_valid) begin
      sk.push_back(out_key);
      sf.push_back(out_flag);
      sc.push_back(cyc);
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] fb [0:63];
  int         flen;
  int         tlast_cyc;

  task automatic build(input logic [15:0] etype, input logic [7:0] vihl, input logic [7:0] proto,
                       input logic [31:0] src, input logic [31:0] dst,
                       input logic [15:0] sport, input logic [15:0] dport, input int len);
    for (int i = 0; i < 64; i++) fb[i] = 8'(i) ^ 8'hA5;
    flen   = len;
    fb[12] = etype[15:8]; fb[13] = etype[7:0];
    fb[14] = vihl;
    fb[23] = proto;
    fb[26] = src[31:24];  fb[27] = src[23:16]; fb[28] = src[15:8]; fb[29] = src[7:0];
    fb[30] = dst[31:24];  fb[31] = dst[23:16]; fb[32] = dst[15:8]; fb[33] = dst[7:0];
    fb[34] = sport[15:8]; fb[35] = sport[7:0];
    fb[36] = dport[15:8]; fb[37] = dport[7:0];
  endtask

  // Drive the frame in fb. Optional tvalid gap after beat gap_beat, optional
  // reset release just before beat rel_beat. Returns at posedge + 1.
  task automatic send(input bit tuser, input int gap_beat, input int gap_len, input int rel_beat);
    int nbeats;
    nbeats = (flen + 7) / 8;
    for (int b = 0; b < nbeats; b++) begin
      if (b == rel_beat) rst = 1'b0;
      for (int j = 0; j < 8; j++) begin
        if (8*b + j < flen) begin
          axis_if.tdata[8*j +: 8] = fb[8*b + j];
          axis_if.tkeep[j]        = 1'b1;
        end else begin
          axis_if.tdata[8*j +: 8] = 8'h00;
          axis_if.tkeep[j]        = 1'b0;
        end
      end
      axis_if.tvalid = 1'b1;
      axis_if.tlast  = (b == nbeats - 1);
      axis_if.tuser  = (b == nbeats - 1) ? tuser : 1'b0;
      if (b == nbeats - 1) tlast_cyc = cyc;
      @(posedge clk); #1;
      if (b == gap_beat) begin
        axis_if.tvalid = 1'b0;
        repeat (gap_len) begin @(posedge clk); #1; end
      end
    end
    axis_if.tvalid = 1'b0;
    axis_if.tlast  = 1'b0;
    axis_if.tuser  = 1'b0;
  endtask

  task automatic settle();
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic clear_rec();
    sk.delete(); sf.delete(); sc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_tlast;
    logic [15:0] bad_etype [4];
    logic [7:0]  bad_vihl  [4];
    logic [7:0]  bad_proto [4];
    int          bad_len   [4];
    bad_etype = '{16'h86DD, 16'h0800, 16'h0800, 16'h0800};
    bad_vihl  = '{8'h45,    8'h46,    8'h45,    8'h45};
    bad_proto = '{8'd17,    8'd17,    8'd6,     8'd17};
    bad_len   = '{64,       64,       64,       32};

    rst = 1'b1;
    axis_if.tdata = '0; axis_if.tkeep = '0;
    axis_if.tvalid = 1'b0; axis_if.tlast = 1'b0; axis_if.tuser = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_key",   out_key,   96'h0);
    check("rst_flag",  out_flag,  4'h0);
    check("rst_stat",  stat_keys, 32'h0);

    // Reset released mid-frame: that frame is discarded, the next one keys.
    clear_rec();
    build(16'h0800, 8'h45, 8'd17, 32'h0A000007, 32'h0A000008, 16'd53, 16'd4444, 64);
    send(1'b0, -1, 0, 3);
    build(16'h0800, 8'h45, 8'd17, 32'h0A000001, 32'h0A000002, 16'd53, 16'd4444, 64);
    send(1'b0, -1, 0, -1);
    settle();
    check("midrst_count", sk.size(), 1);
    check("basic_key",  (sk.size() > 0) ? sk[0] : 96'h0, KEY_STD);
    check("basic_flag", (sf.size() > 0) ? sf[0] : 4'h0, 4'h1);
    check("basic_lat",  (sc.size() > 0) ? sc[0] : 0, tlast_cyc + 1);
    check("basic_stat", stat_keys, 32'd1);
    check("basic_hold", out_key, KEY_STD);

    // Non-alert source port -> lookup.
    clear_rec();
    build(16'h0800, 8'h45, 8'd17, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd4444, 64);
    send(1'b0, -1, 0, -1);
    settle();
    check("lookup_count", sk.size(), 1);
    check("lookup_key",  (sk.size() > 0) ? sk[0] : 96'h0, KEY_STD);
    check("lookup_flag", (sf.size() > 0) ? sf[0] : 4'h0, 4'h2);
    check("lookup_stat", stat_keys, 32'd2);

    // Bad frame flagged on tlast -> no strobe, outputs hold.
    clear_rec();
    build(16'h0800, 8'h45, 8'd17, 32'h0A000001, 32'h0A000002, 16'd53, 16'd4444, 64);
    send(1'b1, -1, 0, -1);
    settle();
    check("tuser_count", sk.size(), 0);
    check("tuser_stat",  stat_keys, 32'd2);
    check("tuser_hold_flag", out_flag, 4'h2);

    // Frames that must be ignored.
    for (int k = 0; k < 4; k++) begin
      clear_rec();
      build(bad_etype[k], bad_vihl[k], bad_proto[k], 32'h0A000001, 32'h0A000002,
            16'd53, 16'd4444, bad_len[k]);
      send(1'b0, -1, 0, -1);
      settle();
      check($sformatf("drop%0d_count", k), sk.size(), 0);
      check($sformatf("drop%0d_stat", k), stat_keys, 32'd2);
    end

    // Two minimum-length frames back to back.
    clear_rec();
    build(16'h0800, 8'h45, 8'd17, 32'h0A000003, 32'h0A000004, 16'd53, 16'h0050, 40);
    send(1'b0, -1, 0, -1);
    first_tlast = tlast_cyc;
    build(16'h0800, 8'h45, 8'd17, 32'h0A000005, 32'h0A000006, 16'd99, 16'h1F90, 40);
    send(1'b0, -1, 0, -1);
    settle();
    check("b2b_count", sk.size(), 2);
    if (sk.size() == 2) begin
      check("b2b_key0",  sk[0], KEY_C);
      check("b2b_flag0", sf[0], 4'h1);
      check("b2b_key1",  sk[1], KEY_D);
      check("b2b_flag1", sf[1], 4'h2);
      check("b2b_lat0",  sc[0], first_tlast + 1);
      check("b2b_gap",   sc[1] - sc[0], 5);
    end
    check("b2b_stat", stat_keys, 32'd4);

    // tvalid gap of 3 cycles between beats 2 and 3.
    clear_rec();
    build(16'h0800, 8'h45, 8'd17, 32'h0A000001, 32'h0A000002, 16'd53, 16'd4444, 64);
    send(1'b0, 2, 3, -1);
    settle();
    check("gap_count", sk.size(), 1);
    check("gap_key",  (sk.size() > 0) ? sk[0] : 96'h0, KEY_STD);
    check("gap_flag", (sf.size() > 0) ? sf[0] : 4'h0, 4'h1);
    check("gap_stat", stat_keys, 32'd5);

    // Counter wrap.
    force dut.stat_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.stat_q;
    @(posedge clk); #1;
    check("wrap_pre", stat_keys, 32'hFFFF_FFFF);
    clear_rec();
    build(16'h0800, 8'h45, 8'd17, 32'h0A000001, 32'h0A000002, 16'd53, 16'd4444, 64);
    send(1'b0, -1, 0, -1);
    settle();
    check("wrap_count", sk.size(), 1);
    check("wrap_stat",  stat_keys, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pkt_key_extract.md
# pkt_key_extract

Upstream parser for the key/value database path. Taps the 64-bit receive AXI4-Stream, recognises Ethernet/IPv4/UDP frames, and builds the 96-bit tuple key plus a 4-bit operation flag. Emits one single-cycle key/flag/valid strobe per accepted frame, directly into the database top-level inputs (`in_key`, `in_flag`, `in_valid`).

## Interface
- `KEY_SIZE`, 96: key width; only 96 is supported.
- `ALERT_PORT`, 16'd53: UDP source port that marks a frame as an insert candidate.
- `clk` in 1: single clock, all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `s_axis_tdata` in 64: frame data; wire byte 0 of each beat is `[7:0]`.
- `s_axis_tkeep` in 8: byte enables.
- `s_axis_tvalid` in 1: beat valid. Passive tap with no `tready`; every valid beat is consumed.
- `s_axis_tlast` in 1: last beat of frame.
- `s_axis_tuser` in 1: sampled only on the tlast beat; 1 means the frame is bad (FCS or other error).
- `out_key` out KEY_SIZE: {src IP[31:0], dst IP[31:0], UDP dst port[15:0], 16'h0}. The first wire byte of each field is its MSB.
- `out_flag` out 4: `OP_INSERT` = 4'h1 or `OP_LOOKUP` = 4'h2.
- `out_valid` out 1: one-cycle strobe qualifying `out_key` and `out_flag`.
- `stat_keys` out 32: count of `out_valid` strobes, wraps at 2^32.

## Operation
- Beat index k covers wire bytes 8k..8k+7. The fields used are:
  - ethertype: beat 1, bytes 4–5; must be 0x0800.
  - version/IHL: beat 1, byte 6; must be 0x45.
  - protocol: beat 2, byte 7; must be 17.
  - src IP: beat 3, bytes 2–5.
  - dst IP: beat 3, bytes 6–7 and beat 4, bytes 0–1.
  - UDP src port: beat 4, bytes 2–3.
  - UDP dst port: beat 4, bytes 4–5; beat 4 tkeep[5:0] must be all ones.
- Frames with VLAN tags, IP options, or non-UDP protocols are silently ignored. They produce no strobe and no counter change.
- Flag: `OP_INSERT` if UDP src port == `ALERT_PORT`, else `OP_LOOKUP`.
- FSM states:
  - `SYNC` (entered on reset): discard beats until a tlast beat, then go to `IDLE`. This prevents parsing a frame that was mid-flight when reset released.
  - `IDLE`: a valid beat is beat 0. If it carries tlast, stay in `IDLE`; otherwise go to `HDR` with beat counter = 1.
  - `HDR`: check or capture fields per beat index.
    - Any failed check → `DROP`, or `IDLE` if that beat carries tlast.
    - tlast arriving before beat 4 → `IDLE`, no strobe.
    - After beat 4 passes without tlast → `EOF`.
    - Beat 4 passing with tlast → emit the strobe (if tuser = 0) and go to `IDLE`.
  - `EOF`: wait for tlast. Emit the strobe if tuser = 0, then go to `IDLE`.
  - `DROP`: wait for tlast, then go to `IDLE`.
- The beat counter is 3 bits and saturates at 5. Beats are counted only while tvalid = 1; tvalid gaps stall parsing without affecting state.

## Timing
- Reset values: `out_valid` = 0, `out_key` = 0, `out_flag` = 0, `stat_keys` = 0, FSM = `SYNC`.
- Latency: `out_valid` is high exactly one cycle, in the cycle after the tlast beat is sampled.
- `out_key` and `out_flag` are registered, change only with `out_valid`, and hold until the next strobe.
- `stat_keys` increments in the same cycle `out_valid` is high.
- Back-to-back frames: beat 0 of the next frame may arrive the cycle after tlast, while `out_valid` is high. Both are handled with no lost beat.
- Throughput: at most one strobe per 5 beats, because the minimum accepted frame is 5 beats.
- Reset asserted mid-frame: the in-progress frame produces no strobe; the block returns to `SYNC`.

## Structure
- Shared package `db_pkg` holds:
  - `OP_INSERT` and `OP_LOOKUP`, also consumed by the database controller;
  - `ETH_TYPE_IPV4`, `IP_VER_IHL`, `IP_PROTO_UDP`;
  - the FSM state enum.
- Byte offsets stay local constants in this module.
- One sub-module is natural: `axis_beat_cnt`, a saturating beat-index counter with SOF/EOF tracking.

## Test plan
- After reset, a 64-byte UDP frame with src 10.0.0.1, dst 10.0.0.2, sport 53, dport 4444, tuser = 0 → one `out_valid` pulse the cycle after tlast, `out_key` = 96'h0A000001_0A000002_115C_0000, `out_flag` = 4'h1, `stat_keys` = 1.
- Same frame with sport 1234 → `out_flag` = 4'h2; same frame with tuser = 1 on tlast → no strobe, `stat_keys` unchanged.
- Frames that must each produce no strobe: ethertype 0x86DD, IHL byte 0x46, protocol 6, and a 4-beat frame ending before beat 4 is complete.
- Reset released in the middle of a valid UDP frame, followed by a second valid frame → exactly one strobe, carrying the second frame's key.
- Two valid 5-beat frames back-to-back with no idle cycle → two strobes 5 cycles apart with correct keys.
- tvalid deasserted for 3 cycles between beats 2 and 3 → the same key as the gap-free frame.
- Force `stat_keys` to 32'hFFFFFFFF, then send one valid frame → counter wraps to 0.
